led_matrix_scan_ctrl: RTL
=========================

Name: led_matrix_scan_ctrl

Overview:
Row-scan controller for the 8x8 RGB LED matrix. It holds a double-buffered 8-row x 24-bit frame store and multiplexes one row at a time onto led_row/led_col_r/g/b, with a blanking gap between rows. A pattern generator such as the marquee logic writes rows into the back buffer and requests a buffer swap. The swap is applied only at a frame boundary, so a frame is never shown half old and half new.

Parameters:
DIVIDER, 50_000, clk cycles each row is shown (SHOW phase); must be >= 2
BLANK, 16, clk cycles all rows/columns are off before each row is shown; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  write strobe into back buffer; accepted when wr_en && wr_ready
wr_row  in  3  row index to write
wr_rgb  in  24  {r[7:0], g[7:0], b[7:0]}; bit=1 means LED on
wr_ready  out  1  write accepted this cycle when high
swap_req  in  1  request front/back swap; level or pulse
swap_ack  out  1  one-cycle pulse when swap is performed
frame_tick  out  1  one-cycle pulse on row 7 -> row 0 wrap
led_row  out  8  one-hot, active-high row select
led_col_r  out  8  red columns, active-low (0 = lit)
led_col_g  out  8  green columns, active-low
led_col_b  out  8  blue columns, active-low

Behaviour:
- One clock; reset is synchronous and active-high: clk and rst.
- Reset values:
  - state=BLANK, row_idx=0, cnt=0, front bank=0, both banks cleared to 0, swap pending=0.
  - Outputs: led_row=8'h00, all led_col_*=8'hFF, wr_ready=1, swap_ack=0, frame_tick=0.
- Reset mid-scan or mid-swap takes effect on the next edge and returns everything to the reset values; pending swaps and buffer contents are lost.
- FSM BLANK:
  - led_row=0, columns=8'hFF.
  - cnt counts 0..BLANK-1.
  - On the last count: latch front[row_idx] into a row register, go to SHOW, cnt=0.
- FSM SHOW:
  - led_row = 1<<row_idx.
  - Columns = ~latched r/g/b; registered, no glitch from concurrent writes.
  - cnt counts 0..DIVIDER-1.
  - On the last count: go to BLANK and row_idx=row_idx+1 (mod 8).
- Row period = BLANK+DIVIDER cycles; frame period = 8x that.
- Frame boundary = last SHOW cycle of row 7.
  - frame_tick=1 in the following cycle, i.e. first BLANK cycle of row 0.
- Writes:
  - Go to back bank = ~front.
  - Write data is visible only after a swap.
  - A write to a row is atomic (24 bits in one cycle).
- Swap:
  - swap_req sets pending.
  - At the frame boundary, if pending, or if swap_req is high in that same cycle: toggle front, clear pending, swap_ack=1 the next cycle (coincident with frame_tick).
  - Row 0 of the new frame latches from the new front bank.
- wr_ready is registered as ~pending; it drops the cycle after swap_req and returns high the cycle after the swap.
  - A write in the same cycle as swap_req is accepted into the old back bank.
- swap_req held high after swap_ack re-arms pending, so a swap occurs at every frame boundary.
- The new front bank keeps its contents; the old front bank becomes the back bank unchanged. No copy or clear is performed.

Optional Feature:
LED_SCAN_DIM_EN:
- Defined: adds input dim[1:0]. Columns are enabled only while SHOW cnt < (DIVIDER>>dim), else 8'hFF; led_row still asserted for the full SHOW. dim is sampled at the BLANK->SHOW transition.
- Undefined: no dim port; columns are driven for the whole SHOW phase.

Test Plan:
Use DIVIDER=4, BLANK=2 (row period 6, frame period 48) for all scenarios.
1. Reset -> led_row=00, cols=FF, wr_ready=1. After release: 2 BLANK cycles, then led_row=01 for 4 cycles, cols=FF (buffers empty).
2. Write row3 = r=8'hA5,g=0,b=0; swap_req pulse -> wr_ready=0 until boundary. swap_ack and frame_tick pulse on the same cycle. In the next frame, row 3 SHOW shows led_row=08, led_col_r=5A, g=b=FF.
3. After swap, write back bank row3=24'hFFFFFF without swap -> display still shows 5A on red; no change.
4. Assert swap_req exactly on the row-7 last SHOW cycle -> swap that boundary, swap_ack next cycle. Write in that cycle lands in old back bank.
5. Apply rst during SHOW of row 5 -> next cycle all outputs at reset values. The next displayed frame is blank.
6. (LED_SCAN_DIM_EN) dim=2 -> columns lit for 1 of 4 SHOW cycles. dim=0 -> lit for all 4.

Source files
------------

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan controller for an 8x8 RGB LED matrix with a double-buffered frame store.
// Optional column dimming is enabled by defining LED_SCAN_DIM_EN (adds the dim[1:0] input).
module led_matrix_scan_ctrl #(
    parameter int DIVIDER = 50_000,
    parameter int BLANK   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_row,
    input  logic [23:0] wr_rgb,
    output logic        wr_ready,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        frame_tick,
`ifdef LED_SCAN_DIM_EN
    input  logic [1:0]  dim,
`endif
    output logic [7:0]  led_row,
    output logic [7:0]  led_col_r,
    output logic [7:0]  led_col_g,
    output logic [7:0]  led_col_b
);
    localparam int MAXC = (DIVIDER > BLANK) ? DIVIDER : BLANK;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIVIDER - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    row_idx;
    logic          front;
    logic          pending;
    logic [23:0]   bank [2][8];
    logic [23:0]   row_lat;
`ifdef LED_SCAN_DIM_EN
    logic [1:0]    dim_r;
`endif

    logic boundary;
    logic swap_now;

    // The last SHOW cycle of row 7 is the only point where the front bank may change.
    assign boundary = (state == ST_SHOW) && (cnt == DIV_LAST) && (row_idx == 3'd7);
    assign swap_now = boundary && (pending || swap_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            row_idx    <= '0;
            front      <= 1'b0;
            pending    <= 1'b0;
            row_lat    <= '0;
            for (int i = 0; i < 8; i++) begin
                bank[0][i] <= '0;
                bank[1][i] <= '0;
            end
            wr_ready   <= 1'b1;
            swap_ack   <= 1'b0;
            frame_tick <= 1'b0;
            led_row    <= 8'h00;
            {led_col_r, led_col_g, led_col_b} <= '1;
`ifdef LED_SCAN_DIM_EN
            dim_r      <= 2'd0;
`endif
        end else begin
            swap_ack   <= swap_now;
            frame_tick <= boundary;

            // Write uses the pre-swap back bank, so a write in the swap cycle lands in the old back.
            if (wr_en && wr_ready)
                bank[~front][wr_row] <= wr_rgb;

            if (swap_now) begin
                front    <= ~front;
                pending  <= 1'b0;
                wr_ready <= 1'b1;
            end else begin
                pending  <= pending | swap_req;
                wr_ready <= ~(pending | swap_req);
            end

            case (state)
                ST_BLANK: begin
                    if (cnt == BLK_LAST) begin
                        state   <= ST_SHOW;
                        cnt     <= '0;
                        row_lat <= bank[front][row_idx];
                        led_row <= 8'b1 << row_idx;
`ifdef LED_SCAN_DIM_EN
                        dim_r   <= dim;
                        {led_col_r, led_col_g, led_col_b} <=
                            ((DIVIDER >> dim) > 0) ? ~bank[front][row_idx] : '1;
`else
                        {led_col_r, led_col_g, led_col_b} <= ~bank[front][row_idx];
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == DIV_LAST) begin
                        state   <= ST_BLANK;
                        cnt     <= '0;
                        row_idx <= row_idx + 3'd1;
                        led_row <= 8'h00;
                        {led_col_r, led_col_g, led_col_b} <= '1;
                    end else begin
                        cnt <= cnt + 1'b1;
`ifdef LED_SCAN_DIM_EN
                        {led_col_r, led_col_g, led_col_b} <=
                            ((int'(cnt) + 1) < (DIVIDER >> dim_r)) ? ~row_lat : '1;
`else
                        {led_col_r, led_col_g, led_col_b} <= ~row_lat;
`endif
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end
endmodule
